input_handshake_ctrl: RTL and testbench

Sequences the processor's IN instruction against the board's 4-bit switch bank and confirm push-button. When the decoder flags an IN instruction, the block stalls the pipeline and waits for a clean, debounced press of the confirm button. It then zero-extends and registers the switch value onto the 32-bit write-back bus and releases the stall with a one-cycle completion pulse. It sits between the control unit (request/stall) and the register-file write-back mux (data/done).

---
 rtl/input_handshake_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_input_handshake_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/input_handshake_ctrl.sv
// ---------------------------------------------------------------------------
// input_handshake_ctrl
//
// Purpose:
//   Sequences the CPU's IN instruction against the board switch bank and the
//   confirm push-button. When the decoder raises in_req the pipeline is
//   stalled until a clean, debounced button press is seen. The switch value
//   is then zero-extended onto the 32-bit write-back bus and a one-cycle done
//   pulse releases the stall.
//
//   A new request must first see the button released for DEBOUNCE_CYCLES
//   samples (ARM). This stops a button still held from the previous IN from
//   confirming the next one.
//
// Ports:
//   clock    in   1       single clock, all state changes on posedge
//   reset    in   1       synchronous, active-high
//   in_req   in   1       IN instruction in decode, held until done
//   chave    in   DATA_W  switch bank (quasi-static)
//   botao    in   1       confirm button, active-high, asynchronous
//   stall    out  1       freeze PC/pipeline (combinational)
//   saida    out  32      captured, zero-extended switch value (registered)
//   done     out  1       one-cycle pulse, saida valid for write-back
//   timeout  out  1       one-cycle pulse together with done when the wait
//                         limit expired (constant 0 without the option)
//
// Build option:
//   INPUT_TIMEOUT_EN  - when defined, a wait counter bounds the time spent in
//                       ARM/WAIT/DEBOUNCE. On expiry the block completes with
//                       saida = 0 and pulses done and timeout together.
// ---------------------------------------------------------------------------
module input_handshake_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DATA_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_req,
  input  logic [DATA_W-1:0] chave,
  input  logic              botao,
  output logic              stall,
  output logic [31:0]       saida,
  output logic              done,
  output logic              timeout
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // -------------------------------------------------------------------------
  if (DATA_W == 0 || DATA_W > 32) begin : g_bad_data_w
    $error("input_handshake_ctrl: DATA_W must be in 1..32");
  end
  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $error("input_handshake_ctrl: DEBOUNCE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("input_handshake_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  // -------------------------------------------------------------------------
  // Types and constants
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_WAIT     = 3'd2,
    S_DEBOUNCE = 3'd3,
    S_CAPTURE  = 3'd4
  } state_t;

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Button synchronizer: two flops, the FSM only ever looks at btn_s_q
  // -------------------------------------------------------------------------
  logic btn_meta_q;
  logic btn_s_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
    end else begin
      btn_meta_q <= botao;
      btn_s_q    <= btn_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Zero extension of the switch bank onto the 32-bit bus
  // -------------------------------------------------------------------------
  logic [31:0] chave_ext;

  for (genvar gi = 0; gi < 32; gi++) begin : g_ext
    if (gi < DATA_W) begin : g_bit
      assign chave_ext[gi] = chave[gi];
    end else begin : g_zero
      assign chave_ext[gi] = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      saida_q,   saida_d;
  logic             done_q,    done_d;
  logic             timeout_q, timeout_d;

  // Saturating increment of the debounce counter; it can never wrap.
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = (cnt_q == DEB_MAX) ? DEB_MAX : (cnt_q + CNT_ONE);

  // States in which the CPU is waiting on the button.
  logic busy;
  assign busy = (state_q == S_ARM) || (state_q == S_WAIT) ||
                (state_q == S_DEBOUNCE);

`ifdef INPUT_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;
  assign wait_inc = (wait_q == WAIT_MAX) ? WAIT_MAX : (wait_q + WAIT_ONE);
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    saida_d   = saida_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
`ifdef INPUT_TIMEOUT_EN
    wait_d    = wait_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef INPUT_TIMEOUT_EN
        wait_d = '0;
`endif
        if (in_req) begin
          state_d = S_ARM;
        end
      end

      // Count consecutive released samples; any pressed sample restarts.
      S_ARM: begin
        if (btn_s_q) begin
          cnt_d = '0;
        end else if (cnt_inc == DEB_MAX) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // The first pressed sample already counts as one.
      S_WAIT: begin
        if (btn_s_q) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            state_d = S_CAPTURE;
            saida_d = chave_ext;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_DEBOUNCE;
            cnt_d   = CNT_ONE;
          end
        end
      end

      S_DEBOUNCE: begin
        if (!btn_s_q) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_MAX) begin
          // Switches are sampled on the edge that enters CAPTURE.
          state_d = S_CAPTURE;
          saida_d = chave_ext;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_CAPTURE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef INPUT_TIMEOUT_EN
    // Wait limit. A real confirmation on the same edge takes precedence,
    // since the user did supply a value.
    if (busy) begin
      wait_d = wait_inc;
      if ((wait_inc == WAIT_MAX) && (state_d != S_CAPTURE)) begin
        state_d   = S_CAPTURE;
        saida_d   = '0;
        done_d    = 1'b1;
        timeout_d = 1'b1;
        cnt_d     = '0;
      end
    end
`endif

    // Branch flush: dropping in_req while waiting abandons the request
    // without completing it and leaves saida untouched.
    if (busy && !in_req) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      saida_d   = saida_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
`ifdef INPUT_TIMEOUT_EN
      wait_d    = '0;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // FSM registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      saida_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
      wait_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      saida_q   <= saida_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
`ifdef INPUT_TIMEOUT_EN
      wait_q    <= wait_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // stall is released in CAPTURE so the CPU advances on the done cycle.
  assign stall = ((state_q == S_IDLE) && in_req) || busy;
  assign saida = saida_q;
  assign done  = done_q;

`ifdef INPUT_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_input_handshake_ctrl.sv
// ---------------------------------------------------------------------------
// tb_input_handshake_ctrl
//
// Directed bench for input_handshake_ctrl with DEBOUNCE_CYCLES=4, DATA_W=4
// and TIMEOUT_CYCLES=16. Inputs change 1 ns after each rising edge and
// outputs are sampled at the same point. Expected cycle indices below count
// calls of cyc() since the last begin_phase().
// ---------------------------------------------------------------------------
module tb_input_handshake_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_req;
  logic [3:0]  chave;
  logic        botao;
  logic        stall;
  logic [31:0] saida;
  logic        done;
  logic        timeout;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Per-phase observations
  int   done_cnt;
  int   to_cnt;
  int   stall_bad;
  int   done_idx;
  int   to_idx;
  int   cyc_idx;
  int   consec_cnt = 0;
  logic prev_done  = 1'b0;

  always #5 clock = ~clock;

  input_handshake_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .DATA_W          (4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in_req  (in_req),
    .chave   (chave),
    .botao   (botao),
    .stall   (stall),
    .saida   (saida),
    .done    (done),
    .timeout (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic begin_phase();
    done_cnt  = 0;
    to_cnt    = 0;
    stall_bad = 0;
    done_idx  = 0;
    to_idx    = 0;
    cyc_idx   = 0;
  endtask

  // One clock with the given button level; records done/timeout and checks
  // that, while a request is pending, stall is low exactly on done cycles.
  task automatic cyc(input logic b);
    botao = b;
    @(posedge clock);
    #1;
    cyc_idx++;
    if (done) begin
      done_cnt++;
      done_idx = cyc_idx;
    end
    if (timeout) begin
      to_cnt++;
      to_idx = cyc_idx;
    end
    if (done && prev_done) consec_cnt++;
    prev_done = done;
    if (in_req && (stall !== !done)) stall_bad++;
  endtask

  initial begin
    reset  = 1'b1;
    in_req = 1'b1;
    chave  = 4'hB;
    botao  = 1'b0;

    // ---------------- reset ----------------
    begin_phase();
    cyc(1'b0);
    cyc(1'b0);
    check_eq("rst_saida",   saida, 32'h0);
    check_eq("rst_done",    32'(done), 32'h0);
    check_eq("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;
    #1;
    check_eq("rst_stall_comb", 32'(stall), 32'h1);

    // ---------------- nominal capture ----------------
    // ARM done by call 5, btn_s high seen at call 13, capture at call 16.
    begin_phase();
    repeat (10) cyc(1'b0);
    repeat (8)  cyc(1'b1);
    check_eq("nom_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("nom_done_idx", 32'(done_idx), 32'd16);
    check_eq("nom_saida",    saida, 32'h0000000B);
    check_eq("nom_stall",    32'(stall_bad), 32'd0);
    check_eq("nom_timeout",  32'(to_cnt), 32'd0);

    in_req = 1'b0;
    repeat (3) cyc(1'b0);

    // ---------------- abort in DEBOUNCE ----------------
    begin_phase();
    chave  = 4'h3;
    in_req = 1'b1;
    repeat (5) cyc(1'b0);   // reaches WAIT
    repeat (4) cyc(1'b1);   // DEBOUNCE with two good samples
    in_req = 1'b0;
    cyc(1'b1);
    check_eq("abort_stall", 32'(stall), 32'h0);
    repeat (4) cyc(1'b1);
    check_eq("abort_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("abort_saida",    saida, 32'h0000000B);

    repeat (3) cyc(1'b0);

    // ---------------- bounce rejection ----------------
    // FSM sees pattern two calls late: runs of 2 and 3 are rejected, the
    // steady run completes on its 4th sample at call 18.
    begin_phase();
    chave  = 4'h6;
    in_req = 1'b1;
    repeat (5) cyc(1'b0);
    cyc(1'b1); cyc(1'b1); cyc(1'b0);
    cyc(1'b1); cyc(1'b1); cyc(1'b1); cyc(1'b0);
    repeat (8) cyc(1'b1);
    check_eq("bounce_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("bounce_done_idx", 32'(done_idx), 32'd18);
    check_eq("bounce_saida",    saida, 32'h00000006);
    check_eq("bounce_stall",    32'(stall_bad), 32'd0);

    in_req = 1'b0;
    repeat (3) cyc(1'b1);   // button held before the next request

    // ---------------- held button ----------------
    begin_phase();
    chave  = 4'hF;
    in_req = 1'b1;
    repeat (10) cyc(1'b1);
    check_eq("held_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("held_saida",    saida, 32'h00000006);
    check_eq("held_stall",    32'(stall_bad), 32'd0);
    begin_phase();
    repeat (6) cyc(1'b0);
    repeat (8) cyc(1'b1);
    check_eq("held_rel_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("held_rel_done_idx", 32'(done_idx), 32'd12);
    check_eq("held_rel_saida",    saida, 32'h0000000F);

    in_req = 1'b0;
    repeat (3) cyc(1'b0);

    // ---------------- wait limit ----------------
    begin_phase();
    in_req = 1'b1;
`ifdef INPUT_TIMEOUT_EN
    // ARM entered at call 1, counter reaches 16 on call 17.
    repeat (25) cyc(1'b0);
    check_eq("to_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("to_done_idx", 32'(done_idx), 32'd17);
    check_eq("to_pulse_cnt", 32'(to_cnt), 32'd1);
    check_eq("to_pulse_idx", 32'(to_idx), 32'd17);
    check_eq("to_saida",    saida, 32'h0);
`else
    repeat (100) cyc(1'b0);
    check_eq("noto_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("noto_pulse_cnt", 32'(to_cnt), 32'd0);
    check_eq("noto_stall",    32'(stall_bad), 32'd0);
    check_eq("noto_saida",    saida, 32'h0000000F);
`endif

    in_req = 1'b0;
    repeat (3) cyc(1'b0);

    // ---------------- reset mid-operation ----------------
    begin_phase();
    in_req = 1'b1;
    repeat (6) cyc(1'b0);   // waiting in WAIT
    reset = 1'b1;
    cyc(1'b0);
    check_eq("midrst_saida", saida, 32'h0);
    check_eq("midrst_stall", 32'(stall), 32'h1);
    reset  = 1'b0;
    in_req = 1'b0;
    #1;
    check_eq("midrst_idle_stall", 32'(stall), 32'h0);
    repeat (8) cyc(1'b0);
    check_eq("midrst_done_cnt", 32'(done_cnt), 32'd0);

    check_eq("done_never_consecutive", 32'(consec_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
